// File: rtl/tt_check_pkg.sv
// Shared definitions for the exhaustive truth-table checker: FSM encoding and
// sizing helpers derived from the number of DUT inputs.
package tt_check_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_WAIT  = S_WAIT,
        ST_CHECK = S_CHECK,
        ST_DONE  = S_DONE
    } state_t;

    function automatic int unsigned num_vectors(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

    // One extra bit so a sweep where every vector fails still fits.
    function automatic int unsigned count_width(input int unsigned n_in);
        return n_in + 32'd1;
    endfunction

endpackage

// File: rtl/tt_vector_seq.sv
// Vector counter and settle timer for the truth-table sweep; steered by
// load/advance/count strobes from the checker FSM.
module tt_vector_seq #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            advance,
    input  logic            count,
    output logic [N_IN-1:0] vec,
    output logic            wait_done,
    output logic            last_vec
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    logic [3:0] wcnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            vec  <= '0;
            wcnt <= '0;
        end else if (load) begin
            vec  <= '0;
            wcnt <= SETTLE_CNT;
        end else if (advance) begin
            vec  <= vec + 1'b1;
            wcnt <= SETTLE_CNT;
        end else if (count) begin
            wcnt <= wcnt - 4'd1;
        end
    end

    assign wait_done = (wcnt == 4'd0);
    assign last_vec  = &vec;

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector of a single-output combinational DUT, compares the
// settled output against TRUTH_TABLE and keeps error statistics.
module truth_table_checker
    import tt_check_pkg::*;
#(
    parameter int unsigned                     N_IN        = 3,
    parameter logic [num_vectors(N_IN)-1:0]    TRUTH_TABLE = 8'b00111001,
    parameter int unsigned                     SETTLE      = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop_on_error,
    input  logic                          dut_out,
    output logic [N_IN-1:0]               dut_in,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          error,
    output logic [count_width(N_IN)-1:0]  err_count,
    output logic [N_IN-1:0]               first_fail_vec,
    output logic                          first_fail_valid
);

    state_t          state;
    logic            stop_latched;
    logic [N_IN-1:0] vec;
    logic            wait_done;
    logic            last_vec;
    logic            expected;
    logic            mismatch;
    logic            finish;
    logic            load;
    logic            advance;
    logic            count;

    tt_vector_seq #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_seq (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .advance   (advance),
        .count     (count),
        .vec       (vec),
        .wait_done (wait_done),
        .last_vec  (last_vec)
    );

    assign dut_in   = vec;
    assign expected = TRUTH_TABLE[vec];
    // Case equality so an X or Z from the DUT is reported as a failure.
    assign mismatch = !(dut_out === expected);
    assign finish   = last_vec || (stop_latched && mismatch);

    assign load    = ((state == ST_IDLE) || (state == ST_DONE)) && start;
    assign advance = (state == ST_CHECK) && !finish;
    assign count   = (state == ST_WAIT) && !wait_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= ST_IDLE;
            stop_latched     <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            error            <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            error <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        err_count        <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                        pass             <= 1'b0;
                        done             <= 1'b0;
                        stop_latched     <= stop_on_error;
                        busy             <= 1'b1;
                        state            <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        error     <= 1'b1;
                        err_count <= err_count + 1'b1;
                        if (!first_fail_valid) begin
                            first_fail_vec   <= vec;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    // The terminal test precedes any increment, so vec never wraps.
                    if (finish) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= last_vec && !mismatch && (err_count == '0);
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: two instances (3-input/SETTLE=1 and
// 4-input/SETTLE=0) checked every cycle against a sweep-timeline model.
module tb_truth_table_checker;

    localparam logic [7:0]  TT_A = 8'b00111001;
    localparam logic [15:0] TT_B = 16'hA5C3;

    typedef struct {
        logic busy;
        logic done;
        logic pass;
        logic err;
        logic ffval;
        logic stop;
        int   cnt;
        int   ffv;
        int   dutin;
        int   t;
    } mst_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0, stop_a = 1'b0, start_b = 1'b0, stop_b = 1'b0;
    logic [7:0]  fault_a = 8'h00;
    logic [15:0] fault_b = 16'h0000;
    logic        dut_out_a, dut_out_b;

    logic [2:0]  dut_in_a, ffv_a;
    logic [3:0]  err_count_a;
    logic        busy_a, done_a, pass_a, error_a, ffval_a;
    logic [3:0]  dut_in_b, ffv_b;
    logic [4:0]  err_count_b;
    logic        busy_b, done_b, pass_b, error_b, ffval_b;

    int   compared = 0;
    int   mismatched = 0;
    bit   checking = 1'b0;
    mst_t ma, mb;

    always #5 clock = ~clock;

    // Stand-in combinational DUTs: the golden table with optional faulty rows.
    assign dut_out_a = TT_A[dut_in_a] ^ fault_a[dut_in_a];
    assign dut_out_b = TT_B[dut_in_b] ^ fault_b[dut_in_b];

    truth_table_checker #(.N_IN(3), .TRUTH_TABLE(TT_A), .SETTLE(1)) u_dut_a (
        .clock(clock), .reset(reset), .start(start_a), .stop_on_error(stop_a),
        .dut_out(dut_out_a), .dut_in(dut_in_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .error(error_a), .err_count(err_count_a),
        .first_fail_vec(ffv_a), .first_fail_valid(ffval_a)
    );

    truth_table_checker #(.N_IN(4), .TRUTH_TABLE(TT_B), .SETTLE(0)) u_dut_b (
        .clock(clock), .reset(reset), .start(start_b), .stop_on_error(stop_b),
        .dut_out(dut_out_b), .dut_in(dut_in_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .error(error_b), .err_count(err_count_b),
        .first_fail_vec(ffv_b), .first_fail_valid(ffval_b)
    );

    function automatic mst_t model_reset();
        mst_t z;
        z.busy = 1'b0; z.done = 1'b0; z.pass = 1'b0; z.err = 1'b0;
        z.ffval = 1'b0; z.stop = 1'b0;
        z.cnt = 0; z.ffv = 0; z.dutin = 0; z.t = 0;
        return z;
    endfunction

    // Timeline model: t counts edges since start; vector v is judged at edge (v+1)*per.
    function automatic mst_t model_step(input mst_t s, input logic rst, input logic st,
                                        input logic sp, input int nv, input int per,
                                        input logic [15:0] fault);
        mst_t n;
        int   v;
        if (rst) return model_reset();
        n = s;
        n.err = 1'b0;
        if (!s.busy) begin
            if (st) begin
                n = model_reset();
                n.busy = 1'b1;
                n.stop = sp;
            end
        end else begin
            n.t = s.t + 1;
            if (n.t % per == 0) begin
                v = n.t / per - 1;
                if (fault[v]) begin
                    n.err = 1'b1;
                    n.cnt = s.cnt + 1;
                    if (!s.ffval) begin
                        n.ffv   = v;
                        n.ffval = 1'b1;
                    end
                end
                if (v == nv - 1 || (s.stop && fault[v])) begin
                    n.busy = 1'b0;
                    n.done = 1'b1;
                    n.pass = (n.cnt == 0);
                end else begin
                    n.dutin = v + 1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clock) begin
        ma <= model_step(ma, reset, start_a, stop_a, 8, 3, {8'h00, fault_a});
        mb <= model_step(mb, reset, start_b, stop_b, 16, 2, fault_b);
    end

    task automatic expect_val(input string name, input int actual, input int required);
        compared++;
        if (actual != required) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, actual, required, $time);
        end
    endtask

    task automatic check_inst(input string nm, input mst_t m, input logic b, input logic d,
                              input logic p, input logic e, input logic fv,
                              input int c, input int f, input int di);
        compared++;
        if (b !== m.busy || d !== m.done || p !== m.pass || e !== m.err || fv !== m.ffval ||
            c != m.cnt || f != m.ffv || di != m.dutin) begin
            mismatched++;
            $display("FAIL %s_cycle t=%0t: got busy=%b done=%b pass=%b error=%b cnt=%0d ffv=%0d ffval=%b dut_in=%0d; required busy=%b done=%b pass=%b error=%b cnt=%0d ffv=%0d ffval=%b dut_in=%0d",
                     nm, $time, b, d, p, e, c, f, fv, di,
                     m.busy, m.done, m.pass, m.err, m.cnt, m.ffv, m.ffval, m.dutin);
        end
    endtask

    always @(negedge clock) begin
        if (checking) begin
            check_inst("a", ma, busy_a, done_a, pass_a, error_a, ffval_a,
                       int'(err_count_a), int'(ffv_a), int'(dut_in_a));
            check_inst("b", mb, busy_b, done_b, pass_b, error_b, ffval_b,
                       int'(err_count_b), int'(ffv_b), int'(dut_in_b));
        end
    end

    function automatic logic cur_done(input int w);  return (w != 0) ? done_b : done_a;  endfunction
    function automatic logic cur_busy(input int w);  return (w != 0) ? busy_b : busy_a;  endfunction
    function automatic logic cur_pass(input int w);  return (w != 0) ? pass_b : pass_a;  endfunction
    function automatic logic cur_err(input int w);   return (w != 0) ? error_b : error_a; endfunction
    function automatic logic cur_ffval(input int w); return (w != 0) ? ffval_b : ffval_a; endfunction
    function automatic int cur_cnt(input int w);   return (w != 0) ? int'(err_count_b) : int'(err_count_a); endfunction
    function automatic int cur_ffv(input int w);   return (w != 0) ? int'(ffv_b) : int'(ffv_a); endfunction
    function automatic int cur_dutin(input int w); return (w != 0) ? int'(dut_in_b) : int'(dut_in_a); endfunction

    // Runs one sweep; lat = edges from the start-sampling edge to done, strobes = error pulses seen.
    task automatic sweep(input int w, input logic stop, input logic [15:0] fault, input logic noise,
                         output int lat, output int strobes);
        @(negedge clock);
        if (w == 0) begin fault_a = fault[7:0]; stop_a = stop; start_a = 1'b1; end
        else        begin fault_b = fault;      stop_b = stop; start_b = 1'b1; end
        @(negedge clock);
        start_a = 1'b0;
        start_b = 1'b0;
        expect_val("start_done_cleared", int'(cur_done(w)), 0);
        expect_val("start_busy", int'(cur_busy(w)), 1);
        expect_val("start_count_cleared", cur_cnt(w), 0);
        expect_val("start_dut_in", cur_dutin(w), 0);
        lat = 0;
        strobes = 0;
        while (cur_done(w) == 1'b0 && lat < 300) begin
            if (noise) begin
                if (w == 0) begin start_a = 1'($urandom_range(0, 1)); stop_a = 1'($urandom_range(0, 1)); end
                else        begin start_b = 1'($urandom_range(0, 1)); stop_b = 1'($urandom_range(0, 1)); end
            end
            @(negedge clock);
            lat++;
            if (cur_err(w)) strobes++;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        expect_val("sweep_finished", int'(cur_done(w)), 1);
    endtask

    initial begin
        int          lat, st, n, nv, per, first, exp_cnt, exp_lat;
        logic [15:0] f;
        logic        sp;

        repeat (3) @(negedge clock);
        checking = 1'b1;
        expect_val("reset_busy", int'(busy_a), 0);
        expect_val("reset_dut_in", int'(dut_in_a), 0);
        expect_val("reset_err_count", int'(err_count_b), 0);
        reset = 1'b0;

        // Golden sweep.
        sweep(0, 1'b0, 16'h0000, 1'b0, lat, st);
        expect_val("golden_latency", lat, 24);
        expect_val("golden_pass", int'(pass_a), 1);
        expect_val("golden_count", int'(err_count_a), 0);
        expect_val("golden_ffval", int'(ffval_a), 0);
        expect_val("golden_strobes", st, 0);

        // Vector 3 inverted.
        sweep(0, 1'b0, 16'h0008, 1'b0, lat, st);
        expect_val("v3_latency", lat, 24);
        expect_val("v3_count", int'(err_count_a), 1);
        expect_val("v3_ffv", int'(ffv_a), 3);
        expect_val("v3_ffval", int'(ffval_a), 1);
        expect_val("v3_pass", int'(pass_a), 0);
        expect_val("v3_strobes", st, 1);

        // Stop on first error, faults at 2 and 5.
        sweep(0, 1'b1, 16'h0024, 1'b0, lat, st);
        expect_val("stop_latency", lat, 9);
        expect_val("stop_count", int'(err_count_a), 1);
        expect_val("stop_ffv", int'(ffv_a), 2);
        expect_val("stop_pass", int'(pass_a), 0);
        expect_val("stop_dut_in", int'(dut_in_a), 2);

        // Reset in the middle of a sweep while vector 4 is settling.
        @(negedge clock);
        fault_a = 8'h00; stop_a = 1'b0; start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        n = 0;
        while (dut_in_a != 3'd4 && n < 100) begin
            @(negedge clock);
            n++;
        end
        expect_val("reached_vec4", int'(dut_in_a), 4);
        reset = 1'b1;
        @(negedge clock);
        expect_val("midreset_busy", int'(busy_a), 0);
        expect_val("midreset_dut_in", int'(dut_in_a), 0);
        expect_val("midreset_done", int'(done_a), 0);
        expect_val("midreset_error", int'(error_a), 0);
        reset = 1'b0;
        sweep(0, 1'b0, 16'h0000, 1'b0, lat, st);
        expect_val("after_reset_pass", int'(pass_a), 1);
        expect_val("after_reset_latency", lat, 24);

        // Start pulses and stop_on_error toggles during busy must not disturb the sweep.
        sweep(0, 1'b0, 16'h0040, 1'b1, lat, st);
        expect_val("noisy_latency", lat, 24);
        expect_val("noisy_count", int'(err_count_a), 1);
        expect_val("noisy_ffv", int'(ffv_a), 6);

        // 4-input instance, every output inverted.
        sweep(1, 1'b0, 16'hFFFF, 1'b0, lat, st);
        expect_val("inv_latency", lat, 32);
        expect_val("inv_count", int'(err_count_b), 16);
        expect_val("inv_ffv", int'(ffv_b), 0);
        expect_val("inv_ffval", int'(ffval_b), 1);
        expect_val("inv_pass", int'(pass_b), 0);
        expect_val("inv_strobes", st, 16);

        // Randomized sweeps on both instances.
        for (int i = 0; i < 20; i++) begin
            n   = i % 2;
            nv  = (n != 0) ? 16 : 8;
            per = (n != 0) ? 2 : 3;
            case ($urandom_range(0, 3))
                0:       f = 16'h0000;
                1:       f = 16'($urandom & $urandom & $urandom);
                default: f = 16'($urandom);
            endcase
            if (n == 0) f = f & 16'h00FF;
            sp = 1'($urandom_range(0, 1));
            first = -1;
            exp_cnt = 0;
            for (int k = nv - 1; k >= 0; k--) begin
                if (f[k]) begin
                    first = k;
                    exp_cnt++;
                end
            end
            if (sp && first >= 0) begin
                exp_cnt = 1;
                exp_lat = (first + 1) * per;
            end else begin
                exp_lat = nv * per;
            end
            sweep(n, sp, f, 1'b1, lat, st);
            expect_val("rand_latency", lat, exp_lat);
            expect_val("rand_count", cur_cnt(n), exp_cnt);
            expect_val("rand_strobes", st, exp_cnt);
            expect_val("rand_pass", int'(cur_pass(n)), (first < 0) ? 1 : 0);
            expect_val("rand_ffval", int'(cur_ffval(n)), (first < 0) ? 0 : 1);
            if (first >= 0) expect_val("rand_ffv", cur_ffv(n), first);
        end

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got still running, required finished");
        $fatal(1, "watchdog expired");
    end

endmodule
